// File: rtl/sign_mul_in.sv
// Two-entry FIFO that splits signed operand pairs into sign and magnitude for an unsigned multiplier.
// Latency: 1 cycle from accept to out_valid into an empty FIFO; outputs come from registers only.
// Backpressure: in_ready drops when both entries are full; a pop never lets a push through.
//
// Ports: clk/rst_n (async active-low), flush (sync clear), in_valid/in_ready + data_a/data_b,
//        out_valid/out_ready + mag_a/mag_b/sign_a/sign_b/zero_flag, occupancy (0..2).
// Build option: SIGN_MUL_IN_SAT_EN clamps the most-negative operand to magnitude 2^(WIDTH-1)-1.
module sign_mul_in #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             sign_a,
    output logic             sign_b,
    output logic             zero_flag,
    output logic [1:0]       occupancy
);

    typedef struct packed {
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
        logic             sign_a;
        logic             sign_b;
        logic             zero;
    } entry_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef SIGN_MUL_IN_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAG  = {1'b0, {(WIDTH-1){1'b1}}};
`endif

    // Returns {sign, magnitude}. A zero operand has MSB 0, so its sign is already 0.
    function automatic logic [WIDTH:0] decomp(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] mag;
        logic             sgn;
        sgn = x[WIDTH-1];
        mag = sgn ? (~x + ONE) : x;
`ifdef SIGN_MUL_IN_SAT_EN
        if (x == MOST_NEG) begin
            mag = SAT_MAG;
        end
`else
        // ~x+1 of the most-negative value wraps to itself, which read unsigned
        // is exactly 2^(WIDTH-1), so no special case is needed.
        if (x == MOST_NEG) begin
            mag = MOST_NEG;
        end
`endif
        return {sgn, mag};
    endfunction

    entry_t           mem [2];
    entry_t           wr_ent;
    entry_t           rd_ent;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             init_done;
    logic             push;
    logic             pop;
    logic [WIDTH:0]   dec_a;
    logic [WIDTH:0]   dec_b;

    // init_done keeps in_ready low through reset and until the first edge after release.
    assign in_ready  = init_done && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    always_comb begin
        dec_a         = decomp(data_a);
        dec_b         = decomp(data_b);
        wr_ent        = '0;
        wr_ent.sign_a = dec_a[WIDTH];
        wr_ent.mag_a  = dec_a[WIDTH-1:0];
        wr_ent.sign_b = dec_b[WIDTH];
        wr_ent.mag_b  = dec_b[WIDTH-1:0];
        wr_ent.zero   = (data_a == '0) || (data_b == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wr_ent;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Head entry drives the outputs; contents are meaningless while out_valid is low.
    assign rd_ent    = mem[rd_ptr];
    assign mag_a     = rd_ent.mag_a;
    assign mag_b     = rd_ent.mag_b;
    assign sign_a    = rd_ent.sign_a;
    assign sign_b    = rd_ent.sign_b;
    assign zero_flag = rd_ent.zero;

endmodule

// File: tb/tb_sign_mul_in.sv
// Bench for sign_mul_in: directed scenarios plus randomized traffic against a queue model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// The model accepts a push only while it holds fewer than two entries, before any same-cycle pop.
module tb_sign_mul_in;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         sign_a;
    logic         sign_b;
    logic         zero_flag;
    logic [1:0]   occupancy;

    sign_mul_in #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .zero_flag (zero_flag),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ma;
        int mb;
        bit sa;
        bit sb;
        bit z;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Magnitude from the signed integer value, clamped to the symmetric range when saturating.
    function automatic int mag_of(input logic [W-1:0] x);
        int v;
        v = int'($signed(x));
        if (v < 0) v = -v;
`ifdef SIGN_MUL_IN_SAT_EN
        if (v > (2 ** (W - 1)) - 1) v = (2 ** (W - 1)) - 1;
`endif
        return v;
    endfunction

    function automatic bit sgn_of(input logic [W-1:0] x);
        return int'($signed(x)) < 0;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.ma = mag_of(a);
        e.mb = mag_of(b);
        e.sa = sgn_of(a);
        e.sb = sgn_of(b);
        e.z  = (a == 0) || (b == 0);
        return e;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
        if (q.size() > 0) begin
            check({tag, ".mag_a"},  32'(mag_a),     32'(q[0].ma));
            check({tag, ".mag_b"},  32'(mag_b),     32'(q[0].mb));
            check({tag, ".sign_a"}, 32'(sign_a),    32'(q[0].sa));
            check({tag, ".sign_b"}, 32'(sign_b),    32'(q[0].sb));
            check({tag, ".zero"},   32'(zero_flag), 32'(q[0].z));
            check({tag, ".psign"},  32'(sign_a ^ sign_b), 32'(q[0].sa ^ q[0].sb));
        end
    endtask

    // Called just after a falling edge: drive, advance one rising edge, compare.
    task automatic step(input string tag, input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ordy, input bit fl);
        int sz;
        in_valid  = iv;
        data_a    = a;
        data_b    = b;
        out_ready = ordy;
        flush     = fl;
        sz = q.size();
        if (fl) begin
            q.delete();
        end else begin
            if (ordy && sz > 0) void'(q.pop_front());
            if (iv && sz < 2) q.push_back(model(a, b));
        end
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    function automatic logic [W-1:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return {1'b1, {(W-1){1'b0}}};
        return W'($urandom);
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_a    = '0;
        data_b    = '0;

        // Reset state, held across a clock edge.
        #12;
        check("rst.in_ready",  32'(in_ready),  0);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.occupancy", 32'(occupancy), 0);
        check("rst.mag",       32'({mag_a, mag_b}), 0);
        check("rst.signs",     32'({sign_a, sign_b, zero_flag}), 0);
        #1 rst_n = 1'b1;
        #1 check("rel.in_ready_pre", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check("rel.in_ready_post", 32'(in_ready), 1);

        // Basic decomposition: -3 and 5.
        step("basic", 1, 8'hFD, 8'h05, 0, 0);
        check("basic.mag_a", 32'(mag_a), 3);
        check("basic.sign_a", 32'(sign_a), 1);
        check("basic.mag_b", 32'(mag_b), 5);
        check("basic.sign_b", 32'(sign_b), 0);
        check("basic.zero", 32'(zero_flag), 0);
        step("basic.pop", 0, 8'h00, 8'h00, 1, 0);

        // Zero operand with -100.
        step("zero", 1, 8'h00, 8'h9C, 0, 0);
        check("zero.sign_a", 32'(sign_a), 0);
        check("zero.mag_a", 32'(mag_a), 0);
        check("zero.mag_b", 32'(mag_b), 100);
        check("zero.sign_b", 32'(sign_b), 1);
        check("zero.flag", 32'(zero_flag), 1);
        step("zero.pop", 0, 8'h00, 8'h00, 1, 0);

        // Most-negative boundary.
        step("mneg", 1, 8'h80, 8'h80, 0, 0);
`ifdef SIGN_MUL_IN_SAT_EN
        check("mneg.mag_a", 32'(mag_a), 127);
        check("mneg.mag_b", 32'(mag_b), 127);
`else
        check("mneg.mag_a", 32'(mag_a), 128);
        check("mneg.mag_b", 32'(mag_b), 128);
`endif
        check("mneg.signs", 32'({sign_a, sign_b}), 3);
        step("mneg.pop", 0, 8'h00, 8'h00, 1, 0);

        // Fill to two, third pair held off, then drain 2,1,0.
        step("full1", 1, 8'h11, 8'hF1, 0, 0);
        step("full2", 1, 8'h22, 8'hE2, 0, 0);
        check("full.in_ready", 32'(in_ready), 0);
        check("full.occ", 32'(occupancy), 2);
        step("full3", 1, 8'h33, 8'hD3, 1, 0);
        check("full3.occ", 32'(occupancy), 1);
        check("full3.order", 32'(mag_a), 32'h22);
        step("drain", 0, 8'h00, 8'h00, 1, 0);
        check("drain.occ", 32'(occupancy), 0);

        // Push and pop together at count 1, then flush with a push.
        step("sim.push", 1, 8'h05, 8'h06, 0, 0);
        step("sim.both", 1, 8'hF9, 8'h07, 1, 0);
        check("sim.occ", 32'(occupancy), 1);
        check("sim.order", 32'(mag_a), 7);
        step("flush", 1, 8'h01, 8'h02, 1, 1);
        check("flush.occ", 32'(occupancy), 0);
        check("flush.out_valid", 32'(out_valid), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0), rand_op(), rand_op(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
        end

        // Reset in the middle of operation with two entries buffered.
        step("pre_rst", 0, 8'h00, 8'h00, 1, 1);
        step("mid1", 1, 8'h44, 8'h55, 0, 0);
        step("mid2", 1, 8'h66, 8'h77, 0, 0);
        check("mid.occ", 32'(occupancy), 2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid.rst.out_valid", 32'(out_valid), 0);
        check("mid.rst.occ", 32'(occupancy), 0);
        check("mid.rst.in_ready", 32'(in_ready), 0);
        q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid.rel.in_ready", 32'(in_ready), 1);
        compare_all("mid.rel");
        step("post", 1, 8'hC8, 8'h32, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
